// File: rtl/rvc_asap_5pl_cr_responder.sv
// Control-register responder on the D_MEM bus: 7-seg/LED registers, button/switch sync + debounce.
// Optional CR_SCRATCH_EN adds a 32-bit byte-masked scratch register at offset 0x28.
module rvc_asap_5pl_cr_responder #(
    parameter logic [31:0] CR_BASE         = 32'h0000_C000,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic        Clock,
    input  logic        Rst,
    input  logic [31:0] DMemWrDataQ103H,
    input  logic [31:0] DMemAddressQ103H,
    input  logic [3:0]  DMemByteEnQ103H,
    input  logic        DMemWrEnQ103H,
    input  logic        DMemRdEnQ103H,
    output logic [31:0] DMemRdRspQ104H,
    input  logic        Button_0,
    input  logic        Button_1,
    input  logic [9:0]  Switch,
    output logic [7:0]  SEG7_0,
    output logic [7:0]  SEG7_1,
    output logic [7:0]  SEG7_2,
    output logic [7:0]  SEG7_3,
    output logic [7:0]  SEG7_4,
    output logic [7:0]  SEG7_5,
    output logic [9:0]  LED
);

    localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic             hit, wr_hit, rd_hit;
    logic [5:0]       word_off;
    logic [5:0][7:0]  seg_q, seg_d;
    logic [9:0]       led_q, led_d;
    logic [1:0]       btn_s1_q, btn_s2_q;
    logic [9:0]       sw_s1_q, sw_s2_q;
    logic [1:0]       db_q, db_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0]       evt_q, evt_d, evt_clr;
    logic [31:0]      rd_val, rsp_q, rsp_d;
    logic             unused_bits;

    assign hit      = (DMemAddressQ103H[31:8] == CR_BASE[31:8]);
    assign word_off = DMemAddressQ103H[7:2];
    assign wr_hit   = DMemWrEnQ103H && hit;
    assign rd_hit   = DMemRdEnQ103H && hit;

`ifdef CR_SCRATCH_EN
    logic [31:0] scratch_q, scratch_d;

    always_comb begin
        scratch_d = scratch_q;
        if (wr_hit && word_off == 6'h0A) begin
            for (int b = 0; b < 4; b++) begin
                if (DMemByteEnQ103H[b]) scratch_d[8*b +: 8] = DMemWrDataQ103H[8*b +: 8];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Rst) scratch_q <= '0;
        else     scratch_q <= scratch_d;
    end

    assign unused_bits = ^DMemAddressQ103H[1:0];
`else
    assign unused_bits = ^{DMemAddressQ103H[1:0], DMemWrDataQ103H[31:10]};
`endif

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        for (int k = 0; k < 2; k++) begin
            if (btn_s2_q[k] != db_q[k]) begin
                if (cnt_q[k] == CNT_MAX) db_d[k]  = btn_s2_q[k];
                else                     cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    always_comb begin
        seg_d   = seg_q;
        led_d   = led_q;
        evt_clr = '0;
        if (wr_hit) begin
            for (int i = 0; i < 6; i++) begin
                if (word_off == 6'(i) && DMemByteEnQ103H[0]) seg_d[i] = DMemWrDataQ103H[7:0];
            end
            if (word_off == 6'h06) begin
                if (DMemByteEnQ103H[0]) led_d[7:0] = DMemWrDataQ103H[7:0];
                if (DMemByteEnQ103H[1]) led_d[9:8] = DMemWrDataQ103H[9:8];
            end
            if (word_off == 6'h09 && DMemByteEnQ103H[0]) evt_clr = DMemWrDataQ103H[1:0];
        end
        // A rise in the same cycle as a clear keeps the event
        evt_d = (evt_q & ~evt_clr) | (db_d & ~db_q);
    end

    always_comb begin
        rd_val = '0;
        case (word_off)
            6'h00, 6'h01, 6'h02,
            6'h03, 6'h04, 6'h05: rd_val = {24'b0, seg_q[word_off[2:0]]};
            6'h06:               rd_val = {22'b0, led_q};
            6'h07:               rd_val = {30'b0, db_q};
            6'h08:               rd_val = {22'b0, sw_s2_q};
            6'h09:               rd_val = {30'b0, evt_q};
`ifdef CR_SCRATCH_EN
            6'h0A:               rd_val = scratch_q;
`endif
            default:             rd_val = '0;
        endcase
        rsp_d = rd_hit ? rd_val : 32'b0;
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            seg_q    <= {6{8'hFF}};
            led_q    <= '0;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            db_q     <= '0;
            cnt_q    <= '0;
            evt_q    <= '0;
            rsp_q    <= '0;
        end else begin
            seg_q    <= seg_d;
            led_q    <= led_d;
            btn_s1_q <= {Button_1, Button_0};
            btn_s2_q <= btn_s1_q;
            sw_s1_q  <= Switch;
            sw_s2_q  <= sw_s1_q;
            db_q     <= db_d;
            cnt_q    <= cnt_d;
            evt_q    <= evt_d;
            rsp_q    <= rsp_d;
        end
    end

    assign DMemRdRspQ104H = rsp_q;
    assign SEG7_0 = seg_q[0];
    assign SEG7_1 = seg_q[1];
    assign SEG7_2 = seg_q[2];
    assign SEG7_3 = seg_q[3];
    assign SEG7_4 = seg_q[4];
    assign SEG7_5 = seg_q[5];
    assign LED    = led_q;

endmodule

// File: tb/tb_rvc_asap_5pl_cr_responder.sv
// Bench for rvc_asap_5pl_cr_responder: directed vector table, button sequences, random traffic vs a reference model.
module tb_rvc_asap_5pl_cr_responder;

    localparam logic [31:0] BASE = 32'h0000_C000;
    localparam int          DEB  = 16;

    logic        Clock, Rst;
    logic [31:0] WrData, Addr;
    logic [3:0]  ByteEn;
    logic        WrEn, RdEn;
    logic [31:0] Rsp;
    logic        Button_0, Button_1;
    logic [9:0]  Switch;
    logic [7:0]  S0, S1, S2, S3, S4, S5;
    logic [9:0]  LED;

    rvc_asap_5pl_cr_responder #(.CR_BASE(BASE), .DEBOUNCE_CYCLES(DEB)) dut (
        .Clock(Clock), .Rst(Rst),
        .DMemWrDataQ103H(WrData), .DMemAddressQ103H(Addr), .DMemByteEnQ103H(ByteEn),
        .DMemWrEnQ103H(WrEn), .DMemRdEnQ103H(RdEn), .DMemRdRspQ104H(Rsp),
        .Button_0(Button_0), .Button_1(Button_1), .Switch(Switch),
        .SEG7_0(S0), .SEG7_1(S1), .SEG7_2(S2), .SEG7_3(S3), .SEG7_4(S4), .SEG7_5(S5),
        .LED(LED)
    );

    initial begin
        Clock = 0;
        forever #5 Clock = ~Clock;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0]  m_seg [6];
    logic [9:0]  m_led;
    logic [1:0]  m_evt, m_s, m_b1, m_b2;
    logic [9:0]  m_w1, m_w2;
    logic [31:0] m_scr, m_rsp;
    logic        hb [2][DEB];
    int          nf [2];

    function automatic logic [31:0] mread(input logic [7:0] o);
        if (o <= 8'h14)       return {24'b0, m_seg[o >> 2]};
        else if (o == 8'h18)  return {22'b0, m_led};
        else if (o == 8'h1C)  return {30'b0, m_s};
        else if (o == 8'h20)  return {22'b0, m_w2};
        else if (o == 8'h24)  return {30'b0, m_evt};
`ifdef CR_SCRATCH_EN
        else if (o == 8'h28)  return m_scr;
`endif
        return 32'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_seg[i] = 8'hFF;
        m_led = 0; m_evt = 0; m_s = 0; m_b1 = 0; m_b2 = 0;
        m_w1 = 0; m_w2 = 0; m_scr = 0; m_rsp = 0;
        nf[0] = 0; nf[1] = 0;
    endtask

    task automatic model_edge();
        logic       h, all;
        logic [7:0] o;
        logic [1:0] rise, clr;
        if (Rst) begin
            model_reset();
            return;
        end
        h = (Addr[31:8] == BASE[31:8]);
        o = Addr[7:0] & 8'hFC;
        m_rsp = (RdEn && h) ? mread(o) : 32'b0;
        rise = 0; clr = 0;
        // New level accepted once the last DEB synced samples all differ from it
        for (int k = 0; k < 2; k++) begin
            for (int j = DEB - 1; j > 0; j--) hb[k][j] = hb[k][j-1];
            hb[k][0] = m_b2[k];
            if (nf[k] < DEB) nf[k]++;
            if (nf[k] == DEB) begin
                all = 1;
                for (int j = 0; j < DEB; j++) if (hb[k][j] == m_s[k]) all = 0;
                if (all) begin
                    m_s[k] = ~m_s[k];
                    nf[k] = 0;
                    if (m_s[k]) rise[k] = 1;
                end
            end
        end
        if (WrEn && h) begin
            if (o <= 8'h14 && ByteEn[0]) m_seg[o >> 2] = WrData[7:0];
            if (o == 8'h18) begin
                if (ByteEn[0]) m_led[7:0] = WrData[7:0];
                if (ByteEn[1]) m_led[9:8] = WrData[9:8];
            end
            if (o == 8'h24 && ByteEn[0]) clr = WrData[1:0];
            if (o == 8'h28)
                for (int b = 0; b < 4; b++) if (ByteEn[b]) m_scr[8*b +: 8] = WrData[8*b +: 8];
        end
        m_evt = (m_evt & ~clr) | rise;
        m_b2 = m_b1; m_b1 = {Button_1, Button_0};
        m_w2 = m_w1; m_w1 = Switch;
    endtask

    task automatic step();
        @(posedge Clock);
        model_edge();
        #1;
        chk("rsp", Rsp, m_rsp);
        chk("led", {22'b0, LED}, {22'b0, m_led});
        chk("seg0", {24'b0, S0}, {24'b0, m_seg[0]});
        chk("seg1", {24'b0, S1}, {24'b0, m_seg[1]});
        chk("seg2", {24'b0, S2}, {24'b0, m_seg[2]});
        chk("seg3", {24'b0, S3}, {24'b0, m_seg[3]});
        chk("seg4", {24'b0, S4}, {24'b0, m_seg[4]});
        chk("seg5", {24'b0, S5}, {24'b0, m_seg[5]});
    endtask

    task automatic cyc(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
        WrEn = w; RdEn = r; Addr = a; WrData = d; ByteEn = b;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 32'h0, 4'h0);
    endtask

    typedef struct {
        logic        wr, rd;
        logic [31:0] addr, data;
        logic [3:0]  be;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t tv [$];

    task automatic add(input string nm, input logic w, input logic r, input logic [7:0] off,
                       input logic [31:0] d, input logic [3:0] b, input logic [31:0] e);
        vec_t v;
        v.nm = nm; v.wr = w; v.rd = r; v.addr = BASE + {24'b0, off};
        v.data = d; v.be = b; v.exp = e;
        tv.push_back(v);
    endtask

    initial begin
        logic [31:0] scr_exp;
        logic        lvl0, lvl1;
`ifdef CR_SCRATCH_EN
        scr_exp = 32'hDEAD_0000;
`else
        scr_exp = 32'h0;
`endif
        add("rd_seg0_reset", 0, 1, 8'h00, 0, 4'h0, 32'h0000_00FF);
        add("rd_led_reset",  0, 1, 8'h18, 0, 4'h0, 32'h0);
        add("wr_led_b0",     1, 0, 8'h18, 32'h0000_03A5, 4'b0001, 32'h0);
        add("rd_led_b0",     0, 1, 8'h18, 0, 4'h0, 32'h0000_00A5);
        add("wr_led_b01",    1, 0, 8'h18, 32'h0000_03A5, 4'b0011, 32'h0);
        add("rd_led_b01",    0, 1, 8'h18, 0, 4'h0, 32'h0000_03A5);
        add("wr_rd_seg3",    1, 1, 8'h0C, 32'h0000_0012, 4'hF, 32'h0000_00FF);
        add("rd_seg3",       0, 1, 8'h0C, 0, 4'h0, 32'h0000_0012);
        add("rd_sw",         0, 1, 8'h20, 0, 4'h0, 32'h0000_02B5);
        add("wr_ro_btn",     1, 0, 8'h1C, 32'h3, 4'hF, 32'h0);
        add("rd_ro_btn",     0, 1, 8'h1C, 0, 4'h0, 32'h0);
        add("rd_low_bits",   0, 1, 8'h03, 0, 4'h0, 32'h0000_00FF);
        add("rd_unlisted",   0, 1, 8'h2C, 0, 4'h0, 32'h0);
        add("wr_scratch",    1, 0, 8'h28, 32'hDEAD_BEEF, 4'b1100, 32'h0);
        add("rd_scratch",    0, 1, 8'h28, 0, 4'h0, scr_exp);

        Rst = 1; WrEn = 0; RdEn = 0; Addr = 0; WrData = 0; ByteEn = 0;
        Button_0 = 0; Button_1 = 0; Switch = 10'h2B5;
        model_reset();
        for (int k = 0; k < 2; k++) for (int j = 0; j < DEB; j++) hb[k][j] = 0;
        idle(3);
        Rst = 0;
        idle(3);

        foreach (tv[i]) begin
            cyc(tv[i].wr, tv[i].rd, tv[i].addr, tv[i].data, tv[i].be);
            chk(tv[i].nm, Rsp, tv[i].exp);
        end

        // Out-of-window access changes nothing and reads 0
        cyc(1, 1, BASE + 32'h100, 32'hFFFF_FFFF, 4'hF);
        chk("miss_rsp", Rsp, 32'h0);
        cyc(0, 1, BASE + 32'h0C, 0, 4'h0);
        chk("miss_seg3", Rsp, 32'h12);
        cyc(0, 1, BASE + 32'h18, 0, 4'h0);
        chk("miss_led", Rsp, 32'h3A5);

        // A 10-cycle glitch is rejected
        Button_0 = 1; idle(10);
        Button_0 = 0; idle(25);
        cyc(0, 1, BASE + 32'h1C, 0, 4'h0); chk("glitch_btn", Rsp, 32'h0);
        cyc(0, 1, BASE + 32'h24, 0, 4'h0); chk("glitch_evt", Rsp, 32'h0);

        // Held press: accepted after exactly 2 + DEB edges
        Button_0 = 1; idle(DEB + 1);
        cyc(0, 1, BASE + 32'h1C, 0, 4'h0); chk("press_early", Rsp, 32'h0);
        cyc(0, 1, BASE + 32'h1C, 0, 4'h0); chk("press_on", Rsp, 32'h1);
        idle(11);
        cyc(0, 1, BASE + 32'h24, 0, 4'h0); chk("press_evt", Rsp, 32'h1);
        Button_0 = 0; idle(25);
        Button_1 = 1; idle(25);
        Button_1 = 0; idle(25);
        cyc(0, 1, BASE + 32'h24, 0, 4'h0); chk("evt_both", Rsp, 32'h3);

        // Clear coinciding with a new rise: set wins
        Button_0 = 1; idle(DEB + 1);
        cyc(1, 0, BASE + 32'h24, 32'h1, 4'b0001);
        cyc(0, 1, BASE + 32'h24, 0, 4'h0); chk("set_wins", Rsp, 32'h3);
        cyc(1, 0, BASE + 32'h24, 32'h3, 4'b0001);
        cyc(0, 1, BASE + 32'h24, 0, 4'h0); chk("clr_all", Rsp, 32'h0);

        // Request during reset is discarded
        Rst = 1;
        cyc(1, 1, BASE + 32'h18, 32'h3FF, 4'h3);
        chk("rst_rsp", Rsp, 32'h0);
        chk("rst_led", {22'b0, LED}, 32'h0);
        chk("rst_seg3", {24'b0, S3}, 32'hFF);
        Rst = 0;
        idle(2);

        // Random traffic against the model
        lvl0 = Button_0; lvl1 = Button_1;
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = BASE ^ (32'h1 << $urandom_range(8, 31));
            else a = BASE + {24'b0, 4'($urandom_range(0, 12)), 2'($urandom), 2'b00} + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) lvl0 = ~lvl0;
            if ($urandom_range(0, 29) == 0) lvl1 = ~lvl1;
            if ($urandom_range(0, 49) == 0) Switch = 10'($urandom);
            Button_0 = lvl0; Button_1 = lvl1;
            Rst = ($urandom_range(0, 299) == 0);
            cyc(1'($urandom), 1'($urandom), a, $urandom, 4'($urandom));
        end
        Rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
